// File: rtl/pcm_link_pkg.sv
// Shared state type, default sync header and frame-length helper for the PCM framer.
// Build macro FRAME_PARITY_EN adds a PAR state and a trailing even-parity bit.
package pcm_link_pkg;

`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} frame_state_e;
  localparam int PARITY_BITS = 1;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} frame_state_e;
  localparam int PARITY_BITS = 0;
`endif

  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h00B8;

  function automatic int FRAME_LEN(input int syncW, input int dataW);
    return syncW + dataW + PARITY_BITS;
  endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// One-entry holding buffer between the sample handshake and the framer.
// Unaffected by FRAME_PARITY_EN.
module serializer_hold_buf
  import pcm_link_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A push only arrives while empty, so a push alongside a pop simply refills.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop_i) full_d = 1'b0;
    if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/pcm_frame_serializer.sv
// Serialises buffered samples as SYNC_WORD + sample frames, one bit per bit_en strobe.
// Build macro FRAME_PARITY_EN appends an even-parity bit after the sample.
module pcm_frame_serializer
  import pcm_link_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEFAULT_SYNC_WORD),
  parameter logic              IDLE_BIT  = 1'b0,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              send,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CNT_W = $clog2(((SYNC_W > DATA_W) ? SYNC_W : DATA_W) + 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  frame_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [SYNC_W-1:0] sync_q;
  logic              outBit_q, outValid_q, frameStart_q;
`ifdef FRAME_PARITY_EN
  logic              par_q;
`endif

  logic [DATA_W-1:0] holdData, shiftNext;
  logic              holdFull, launch, frameEnd, headBit;

  serializer_hold_buf #(.DATA_W(DATA_W)) u_holdBuf (
    .clk    (clk),
    .reset  (reset),
    .push_i (in_valid && in_ready),
    .data_i (in_data),
    .pop_i  (launch),
    .data_o (holdData),
    .full_o (holdFull)
  );

  assign in_ready = !holdFull;

  // frameEnd marks the final bit of a frame currently on the line.
`ifdef FRAME_PARITY_EN
  assign frameEnd = (state_q == PAR);
`else
  assign frameEnd = (state_q == DATA) && (cnt_q == DATA_LAST);
`endif
  assign launch    = bit_en && holdFull && send && ((state_q == IDLE) || frameEnd);
  assign headBit   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign shiftNext = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      sync_q       <= '0;
      outBit_q     <= IDLE_BIT;
      outValid_q   <= 1'b0;
      frameStart_q <= 1'b0;
`ifdef FRAME_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else if (bit_en) begin
      frameStart_q <= 1'b0;
      if (launch) begin
        shift_q      <= holdData;
        sync_q       <= SYNC_WORD << 1;
        outBit_q     <= SYNC_WORD[SYNC_W-1];
        outValid_q   <= 1'b1;
        frameStart_q <= 1'b1;
        state_q      <= SYNC;
        cnt_q        <= '0;
`ifdef FRAME_PARITY_EN
        par_q        <= ^holdData;
`endif
      end else begin
        case (state_q)
          SYNC: begin
            if (cnt_q == SYNC_LAST) begin
              state_q  <= DATA;
              cnt_q    <= '0;
              outBit_q <= headBit;
              shift_q  <= shiftNext;
            end else begin
              cnt_q    <= cnt_q + CNT_W'(1);
              outBit_q <= sync_q[SYNC_W-1];
              sync_q   <= sync_q << 1;
            end
          end
          DATA: begin
            if (cnt_q == DATA_LAST) begin
`ifdef FRAME_PARITY_EN
              state_q    <= PAR;
              outBit_q   <= par_q;
`else
              state_q    <= IDLE;
              outBit_q   <= IDLE_BIT;
              outValid_q <= 1'b0;
`endif
            end else begin
              cnt_q    <= cnt_q + CNT_W'(1);
              outBit_q <= headBit;
              shift_q  <= shiftNext;
            end
          end
          default: begin
            state_q    <= IDLE;
            outBit_q   <= IDLE_BIT;
            outValid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_bit     = outBit_q;
  assign out_valid   = outValid_q;
  assign frame_start = frameStart_q;
  assign busy        = outValid_q;

endmodule

// File: tb/tb_pcm_frame_serializer.sv
// Directed bench for pcm_frame_serializer: an MSB-first and an LSB-first instance share stimulus.
// Expected frame lengths follow FRAME_PARITY_EN.
`timescale 1ns/1ps
module tb_pcm_frame_serializer;

`ifdef FRAME_PARITY_EN
   localparam int FLEN = 17;
`else
   localparam int FLEN = 16;
`endif

   typedef struct {
      logic [7:0]  sample;
      logic [15:0] msbLine;
      logic [15:0] lsbLine;
      logic        par;
   } vec_t;

   vec_t vecs[5];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit_en = 1'b0;
   logic       send = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       inReadyM, outBitM, outValidM, frameStartM, busyM;
   logic       inReadyL, outBitL, outValidL, frameStartL, busyL;

   int testsRun = 0;
   int testsFailed = 0;
   int phase = 0;

   pcm_frame_serializer #(.DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hB8), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dutMsb (
      .clk(clk), .reset(reset), .bit_en(bit_en), .send(send), .in_data(in_data), .in_valid(in_valid),
      .in_ready(inReadyM), .out_bit(outBitM), .out_valid(outValidM), .frame_start(frameStartM), .busy(busyM)
   );

   pcm_frame_serializer #(.DATA_W(8), .SYNC_W(8), .SYNC_WORD(8'hB8), .IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) dutLsb (
      .clk(clk), .reset(reset), .bit_en(bit_en), .send(send), .in_data(in_data), .in_valid(in_valid),
      .in_ready(inReadyL), .out_bit(outBitL), .out_valid(outValidL), .frame_start(frameStartL), .busy(busyL)
   );

   always #5 clk = ~clk;

   // Safety net so a stuck design still ends the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired, tests run %0d", testsRun);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   // Every input change and every sample happens 1ns after a rising edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
      phase = (phase + 1) % 4;
      bit_en = (phase == 0);
   endtask

   task automatic nextBit();
      logic hit;
      int guard;
      hit = 1'b0;
      guard = 0;
      while (!hit && guard < 8) begin
         hit = bit_en;
         stepClk();
         guard++;
      end
      checkOutput("strobe seen", hit, 1'b1);
   endtask

   task automatic applyStimulus(input logic [7:0] sample);
      logic rdy;
      int guard;
      rdy = 1'b0;
      guard = 0;
      in_data = sample;
      in_valid = 1'b1;
      while (!rdy && guard < 40) begin
         rdy = inReadyM;
         stepClk();
         guard++;
      end
      in_valid = 1'b0;
      checkOutput("handshake done", rdy, 1'b1);
   endtask

   task automatic checkBit(input int k, input logic [16:0] msbL, input logic [16:0] lsbL);
      checkOutput($sformatf("bit%0d outBit", k), outBitM, msbL[16-k]);
      checkOutput($sformatf("bit%0d lsb outBit", k), outBitL, lsbL[16-k]);
      checkOutput($sformatf("bit%0d outValid", k), outValidM, 1'b1);
      checkOutput($sformatf("bit%0d lsb outValid", k), outValidL, 1'b1);
      checkOutput($sformatf("bit%0d busy", k), busyM, 1'b1);
      checkOutput($sformatf("bit%0d frameStart", k), frameStartM, k == 0);
      checkOutput($sformatf("bit%0d lsb frameStart", k), frameStartL, k == 0);
   endtask

   task automatic checkIdle(input string name);
      checkOutput({name, " outBit"}, outBitM, 1'b0);
      checkOutput({name, " lsb outBit"}, outBitL, 1'b0);
      checkOutput({name, " outValid"}, outValidM, 1'b0);
      checkOutput({name, " busy"}, busyM, 1'b0);
      checkOutput({name, " lsb busy"}, busyL, 1'b0);
      checkOutput({name, " frameStart"}, frameStartM, 1'b0);
   endtask

   task automatic checkRest(input int first, input logic [16:0] msbL, input logic [16:0] lsbL);
      for (int k = first; k < FLEN; k++) begin
         nextBit();
         checkBit(k, msbL, lsbL);
      end
      nextBit();
      checkIdle("after frame");
   endtask

   function automatic logic [16:0] msbOf(input int i);
      return {vecs[i].msbLine, vecs[i].par};
   endfunction

   function automatic logic [16:0] lsbOf(input int i);
      return {vecs[i].lsbLine, vecs[i].par};
   endfunction

   initial begin
      vecs[0] = '{8'h14, 16'hB814, 16'hB828, 1'b0};
      vecs[1] = '{8'h23, 16'hB823, 16'hB8C4, 1'b1};
      vecs[2] = '{8'h68, 16'hB868, 16'hB816, 1'b1};
      vecs[3] = '{8'hFF, 16'hB8FF, 16'hB8FF, 1'b0};
      vecs[4] = '{8'h01, 16'hB801, 16'hB880, 1'b1};

      repeat (3) stepClk();
      reset = 1'b0;
      checkIdle("reset");
      checkOutput("reset inReady", inReadyM, 1'b1);
      checkOutput("reset lsb inReady", inReadyL, 1'b1);

      $display("[TB] single frames from idle");
      for (int v = 0; v < 5; v++) begin
         nextBit();
         applyStimulus(vecs[v].sample);
         checkOutput("loaded inReady", inReadyM, 1'b0);
         checkRest(0, msbOf(v), lsbOf(v));
      end

      $display("[TB] back-to-back frames");
      nextBit();
      applyStimulus(vecs[1].sample);
      checkOutput("b2b loaded inReady", inReadyM, 1'b0);
      in_data = vecs[2].sample;
      in_valid = 1'b1;
      nextBit();
      checkBit(0, msbOf(1), lsbOf(1));
      stepClk();
      in_valid = 1'b0;
      for (int k = 1; k < 2 * FLEN; k++) begin
         nextBit();
         if (k < FLEN) checkBit(k, msbOf(1), lsbOf(1));
         else checkBit(k - FLEN, msbOf(2), lsbOf(2));
         checkOutput($sformatf("b2b bit%0d inReady", k), inReadyM, k >= FLEN);
      end
      nextBit();
      checkIdle("b2b end");

      $display("[TB] send gating");
      send = 1'b0;
      nextBit();
      applyStimulus(vecs[0].sample);
      repeat (5) begin
         nextBit();
         checkIdle("gated");
         checkOutput("gated inReady", inReadyM, 1'b0);
      end
      send = 1'b1;
      checkRest(0, msbOf(0), lsbOf(0));

      $display("[TB] transfer on a strobe cycle");
      for (int g = 0; g < 4 && !bit_en; g++) stepClk();
      checkOutput("aligned to strobe", bit_en, 1'b1);
      in_data = vecs[1].sample;
      in_valid = 1'b1;
      stepClk();
      in_valid = 1'b0;
      checkIdle("coincident strobe");
      checkOutput("coincident inReady", inReadyM, 1'b0);
      checkRest(0, msbOf(1), lsbOf(1));

      $display("[TB] reset mid-frame");
      nextBit();
      applyStimulus(vecs[1].sample);
      for (int k = 0; k <= 13; k++) begin
         nextBit();
         checkBit(k, msbOf(1), lsbOf(1));
         if (k == 0) applyStimulus(vecs[0].sample);
      end
      checkOutput("pre-reset inReady", inReadyM, 1'b0);
      reset = 1'b1;
      stepClk();
      reset = 1'b0;
      checkIdle("mid-frame reset");
      checkOutput("mid-frame reset inReady", inReadyM, 1'b1);
      nextBit();
      checkIdle("post-reset strobe");
      applyStimulus(vecs[2].sample);
      checkRest(0, msbOf(2), lsbOf(2));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
